// File: rtl/sha_pad_256.sv
// sha_pad_256: FIPS 180-4 padding and 512-bit block sequencer for sha_256.
// Ports: clk/rst; in_valid/in_ready/in_data/in_last/in_nbytes word stream;
//   op_i algorithm select; Data/Index/Operation/Enable out to the core;
//   Ready/Hash back from it; digest_o/done_o final result.
// Macro SHA_PAD_SHA224_EN honours op_i and truncates SHA-224 digests.
module sha_pad_256 (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   op_i,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic         in_last,
   input  logic [2:0]   in_nbytes,
   output logic [511:0] Data,
   output logic [63:0]  Index,
   output logic [1:0]   Operation,
   output logic         Enable,
   input  logic         Ready,
   input  logic [255:0] Hash,
   output logic [255:0] digest_o,
   output logic         done_o
);

   typedef enum logic [2:0] {
      IDLE, FILL, PAD, LEN, ISSUE, WAITLAST
   } state_t;

   state_t            state_q, state_d;
   logic [15:0][31:0] buf_q, buf_d;
   logic [4:0]        wp_q, wp_d;
   logic [63:0]       len_q, len_d;
   logic [63:0]       blk_q, blk_d;
   logic              busy_q, busy_d;
   logic              mark_q, mark_d;
   logic              done_q, done_d;
   logic [255:0]      dig_q, dig_d;
   logic              run_q;
   logic              accept, issue;
   logic [2:0]        nb;
   logic [31:0]       word;
   logic [63:0]       bits;

`ifdef SHA_PAD_SHA224_EN
   logic [1:0]        op_q, op_d;
   assign Operation = op_q;
`else
   logic              unused_op;
   assign unused_op = ^op_i;
   assign Operation = 2'd1;
`endif

   // run_q keeps in_ready low while reset is held and rises one cycle after.
   assign in_ready = run_q && (wp_q != 5'd16) &&
                     (state_q == IDLE || state_q == FILL);
   assign accept   = in_valid && in_ready;
   assign issue    = (wp_q == 5'd16) && !busy_q;
   assign nb       = (!in_last || in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
   assign bits     = len_q << 3;

   assign Data     = buf_q;
   assign Enable   = issue;
   assign Index    = blk_q + 64'(issue);
   assign digest_o = dig_q;
   assign done_o   = done_q;

   // Short tail: marker goes straight after the last valid byte.
   always_comb begin
      word = in_data;
      if (in_last) begin
         case (nb)
            3'd1:    word = {in_data[31:24], 24'h80_0000};
            3'd2:    word = {in_data[31:16], 16'h8000};
            3'd3:    word = {in_data[31:8], 8'h80};
            default: word = in_data;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      wp_d    = wp_q;
      len_d   = len_q;
      blk_d   = blk_q;
      mark_d  = mark_q;
      dig_d   = dig_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
`ifdef SHA_PAD_SHA224_EN
      op_d    = op_q;
`endif
      if (Ready)
         busy_d = 1'b0;
      if (issue)
         busy_d = 1'b1;

      unique case (state_q)
         IDLE, FILL: begin
            if (accept) begin
               state_d = FILL;
               len_d   = (state_q == IDLE ? 64'd0 : len_q) + 64'(nb);
               if (state_q == IDLE) begin
                  blk_d = 64'd0;
`ifdef SHA_PAD_SHA224_EN
                  op_d  = op_i;
`endif
               end
               // An empty tail writes nothing; PAD places the marker.
               if (nb != 3'd0) begin
                  buf_d[wp_q[3:0]] = word;
                  wp_d = wp_q + 5'd1;
               end
               if (in_last) begin
                  state_d = PAD;
                  mark_d  = (nb == 3'd4) || (nb == 3'd0);
               end
            end
         end
         PAD: begin
            if (wp_q != 5'd16) begin
               if (mark_q) begin
                  buf_d[wp_q[3:0]] = 32'h8000_0000;
                  wp_d   = wp_q + 5'd1;
                  mark_d = 1'b0;
               end else if (wp_q == 5'd14) begin
                  state_d = LEN;
               end else begin
                  buf_d[wp_q[3:0]] = 32'h0;
                  wp_d = wp_q + 5'd1;
               end
            end
         end
         LEN: begin
            buf_d[wp_q[3:0]] = (wp_q == 5'd14) ? bits[63:32] : bits[31:0];
            wp_d = wp_q + 5'd1;
            if (wp_q == 5'd15)
               state_d = ISSUE;
         end
         ISSUE: begin
            if (issue)
               state_d = WAITLAST;
         end
         WAITLAST: begin
            if (Ready && busy_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
`ifdef SHA_PAD_SHA224_EN
               dig_d = (op_q == 2'd0) ? {Hash[255:32], 32'h0} : Hash;
`else
               dig_d = Hash;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // Core copies Data at Enable, so the buffer is free next cycle.
      if (issue) begin
         wp_d  = 5'd0;
         blk_d = blk_q + 64'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         buf_q   <= '0;
         wp_q    <= 5'd0;
         len_q   <= 64'd0;
         blk_q   <= 64'd0;
         busy_q  <= 1'b0;
         mark_q  <= 1'b0;
         done_q  <= 1'b0;
         dig_q   <= 256'd0;
         run_q   <= 1'b0;
`ifdef SHA_PAD_SHA224_EN
         op_q    <= 2'd1;
`endif
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         wp_q    <= wp_d;
         len_q   <= len_d;
         blk_q   <= blk_d;
         busy_q  <= busy_d;
         mark_q  <= mark_d;
         done_q  <= done_d;
         dig_q   <= dig_d;
         run_q   <= 1'b1;
`ifdef SHA_PAD_SHA224_EN
         op_q    <= op_d;
`endif
      end
   end

endmodule

// File: tb/tb_sha_pad_256.sv
// tb_sha_pad_256: directed bench for sha_pad_256 with a small core model
// that captures each issued block and answers with a Ready pulse.
module tb_sha_pad_256;

   localparam logic [255:0] ABC =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMP =
      256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [223:0] ABC224 =
      224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   op_i;
   logic         in_valid, in_ready, in_last;
   logic [31:0]  in_data;
   logic [2:0]   in_nbytes;
   logic [511:0] Data;
   logic [63:0]  Index;
   logic [1:0]   Operation;
   logic         Enable, Ready, done_o;
   logic [255:0] Hash, digest_o;

   logic         rdy_m = 1'b0;
   logic         force_rdy = 1'b0;
   logic [255:0] hash_val = '0;
   logic [255:0] dig_seen = '0;
   int           n_cmp = 0, n_bad = 0;
   int           cyc = 0, n_en = 0, n_done = 0, viol = 0;
   int           cnt = 0, core_lat = 3;
   bit           outst = 1'b0;
   logic [511:0] cap_d[$];
   logic [63:0]  cap_i[$];
   int           en_cyc[$], rdy_q[$], acc_q[$];

   assign Ready = rdy_m | force_rdy;
   assign Hash  = hash_val;

   sha_pad_256 dut (
      .clk(clk), .rst(rst), .op_i(op_i),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_nbytes(in_nbytes),
      .Data(Data), .Index(Index), .Operation(Operation),
      .Enable(Enable), .Ready(Ready), .Hash(Hash),
      .digest_o(digest_o), .done_o(done_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Core model: copy Data/Index at Enable, answer core_lat cycles later.
   always @(negedge clk) begin
      rdy_m = 1'b0;
      if (rst) begin
         cnt   = 0;
         outst = 1'b0;
      end else begin
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               rdy_m = 1'b1;
               outst = 1'b0;
               rdy_q.push_back(cyc);
            end
         end
         if (Enable) begin
            if (outst) viol++;
            outst = 1'b1;
            n_en++;
            cnt = core_lat;
            cap_d.push_back(Data);
            cap_i.push_back(Index);
            en_cyc.push_back(cyc);
         end
      end
      if (done_o) begin
         n_done++;
         dig_seen = digest_o;
      end
   end

   task automatic chk(input string tag, input logic [255:0] act,
                      input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] wd(input logic [511:0] b, input int k);
      return b[k*32 +: 32];
   endfunction

   function automatic logic [511:0] blk(input int k);
      return (k < cap_d.size()) ? cap_d[k] : '1;
   endfunction

   function automatic logic [63:0] idx(input int k);
      return (k < cap_i.size()) ? cap_i[k] : '1;
   endfunction

   function automatic int qv(input int q[$], input int k);
      return (k < q.size()) ? q[k] : -1000;
   endfunction

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic send(input logic [31:0] d, input bit last,
                       input logic [2:0] n);
      int t;
      t = 0;
      in_valid  = 1'b1;
      in_data   = d;
      in_last   = last;
      in_nbytes = n;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      acc_q.push_back(cyc);
      @(negedge clk);
   endtask

   task automatic wait_done(input int d0);
      int t;
      t = 0;
      while (n_done == d0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", n_done != d0, 1);
   endtask

   int base, d0, rb;

   initial begin
      rst = 1'b1; op_i = 2'd1; in_valid = 1'b0;
      in_data = '0; in_last = 1'b0; in_nbytes = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_enable", Enable, 0);
      chk("rst_done", done_o, 0);
      chk("rst_data", |Data, 0);
      chk("rst_index", Index, 0);
      chk("rst_op", Operation, 1);
      chk("rst_digest", digest_o, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_rise", in_ready, 1);

      // "abc"
      hash_val = ABC; base = n_en; d0 = n_done;
      send(32'h6162_6300, 1'b1, 3'd3);
      in_valid = 1'b0;
      wait_done(d0);
      chk("abc_nen", n_en - base, 1);
      chk("abc_idx", idx(base), 1);
      chk("abc_w0", wd(blk(base), 0), 32'h6162_6380);
      chk("abc_w1_14", |blk(base)[479:32], 0);
      chk("abc_w15", wd(blk(base), 15), 32'h18);
      chk("abc_dig", dig_seen, ABC);
      repeat (4) @(negedge clk);
      chk("abc_hold", digest_o, ABC);
      chk("abc_one_done", n_done - d0, 1);

      // empty message
      hash_val = EMP; base = n_en; d0 = n_done;
      send(32'h0, 1'b1, 3'd0);
      in_valid = 1'b0;
      wait_done(d0);
      chk("emp_w0", wd(blk(base), 0), 32'h8000_0000);
      chk("emp_w1_15", |blk(base)[511:32], 0);
      chk("emp_dig", dig_seen, EMP);

      // 56 bytes: marker and length spill into a second block
      hash_val = {8{32'h5a5a_0001}}; base = n_en; d0 = n_done;
      for (int i = 0; i < 14; i++)
         send(32'hA000_0000 + i, i == 13, 3'd4);
      in_valid = 1'b0;
      wait_done(d0);
      chk("m56_nen", n_en - base, 2);
      chk("m56_idx1", idx(base), 1);
      chk("m56_idx2", idx(base + 1), 2);
      chk("m56_b1w0", wd(blk(base), 0), 32'hA000_0000);
      chk("m56_b1w13", wd(blk(base), 13), 32'hA000_000D);
      chk("m56_b1w14", wd(blk(base), 14), 32'h8000_0000);
      chk("m56_b1w15", wd(blk(base), 15), 32'h0);
      chk("m56_b2w0_14", |blk(base + 1)[479:0], 0);
      chk("m56_b2w15", wd(blk(base + 1), 15), 32'h1C0);
      chk("m56_dig", dig_seen, {8{32'h5a5a_0001}});

`ifdef SHA_PAD_SHA224_EN
      op_i = 2'd0;
      hash_val = {ABC224, 32'hdead_beef}; d0 = n_done;
      send(32'h6162_6300, 1'b1, 3'd3);
      in_valid = 1'b0;
      op_i = 2'd1;
      wait_done(d0);
      chk("s224_op", Operation, 0);
      chk("s224_dig", dig_seen, {ABC224, 32'h0});
`endif

      // backpressure: 20 words held valid, slow core
      core_lat = 30; hash_val = {8{32'h0bad_cafe}};
      base = n_en; d0 = n_done; rb = rdy_q.size();
      acc_q.delete();
      for (int i = 0; i < 20; i++)
         send(32'hB000_0000 + i, i == 19, 3'd4);
      in_valid = 1'b0;
      wait_done(d0);
      chk("bp_nen", n_en - base, 2);
      chk("bp_drop16", qv(en_cyc, base), qv(acc_q, 15) + 1);
      chk("bp_w17", qv(acc_q, 16), qv(en_cyc, base) + 1);
      chk("bp_en2_after_rdy",
          qv(en_cyc, base + 1) > qv(rdy_q, rb), 1);
      chk("bp_b2w3", wd(blk(base + 1), 3), 32'hB000_0013);
      chk("bp_b2w4", wd(blk(base + 1), 4), 32'h8000_0000);
      chk("bp_b2w15", wd(blk(base + 1), 15), 32'h280);
      chk("bp_dig", dig_seen, {8{32'h0bad_cafe}});

      // reset mid-message
      core_lat = 3; d0 = n_done; base = n_en;
      for (int i = 0; i < 5; i++)
         send(32'hC000_0000 + i, 1'b0, 3'd4);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mrst_in_ready", in_ready, 0);
      chk("mrst_data", |Data, 0);
      chk("mrst_index", Index, 0);
      chk("mrst_digest", digest_o, 0);
      chk("mrst_op", Operation, 1);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      force_rdy = 1'b1;
      @(negedge clk);
      force_rdy = 1'b0;
      repeat (5) @(negedge clk);
      chk("mrst_no_done", n_done, d0);
      chk("mrst_no_en", n_en, base);

      hash_val = ABC; d0 = n_done;
      send(32'h6162_6300, 1'b1, 3'd3);
      in_valid = 1'b0;
      wait_done(d0);
      chk("mrst_abc_idx", idx(base), 1);
      chk("mrst_abc_w0", wd(blk(base), 0), 32'h6162_6380);
      chk("mrst_abc_w15", wd(blk(base), 15), 32'h18);
      chk("mrst_abc_dig", dig_seen, ABC);

      chk("no_double_enable", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
